mips_reg_trace_unit: RTL and testbench

//  Synthesizable register-write tracer for the MIPS pipeline. Snoops the regfile write port, filters writes by a
//  run-time register mask and optional change-only mode, and timestamps each event. Buffers events in a FIFO and

---
 rtl/mips_reg_trace_unit_pkg.sv | 26 ++
 rtl/mips_reg_trace_unit_fifo.sv | 53 +++++
 rtl/mips_reg_trace_unit.sv | 118 +++++++++++
 tb/tb_mips_reg_trace_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_reg_trace_unit_pkg.sv
// Shared definitions for the register-write tracer: FSM states, entry layout.
package mips_reg_trace_unit_pkg;

  localparam int REG_W    = 5;
  localparam int NUM_REGS = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } trace_state_t;

  // Entry is {ts, reg, data}; data sits at bit 0.
  function automatic int entry_w(input int ts_w, input int data_w);
    return ts_w + REG_W + data_w;
  endfunction

  function automatic int reg_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int ts_lsb(input int data_w);
    return data_w + REG_W;
  endfunction

endpackage

// File: rtl/mips_reg_trace_unit_fifo.sv
// Synchronous first-word-fall-through FIFO holding trace entries.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module trace_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic             mips_clk,
  input  logic             mips_rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head is shown only while valid so the output reads zero when empty.
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge mips_clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge mips_clk or negedge mips_rst) begin
    if (!mips_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/mips_reg_trace_unit.sv
// Register-write tracer: snoops the regfile write port, filters by mask and
// optional change-only mode, timestamps events and streams them out of a FIFO.
module mips_reg_trace_unit
  import mips_reg_trace_unit_pkg::*;
#(
  parameter  int DATA_W      = 32,
  parameter  int TS_W        = 16,
  parameter  int DEPTH       = 16,
  parameter  int CYCLE_LIMIT = 1000,
  parameter  int CHANGE_ONLY = 0,
  localparam int ENTRY_W     = entry_w(TS_W, DATA_W),
  localparam int LVL_W       = $clog2(DEPTH + 1)
) (
  input  logic               mips_clk,
  input  logic               mips_rst,
  input  logic               trace_en,
  input  logic               clr_stat,
  input  logic [31:0]        trace_mask,
  input  logic               rf_we,
  input  logic [REG_W-1:0]   rf_waddr,
  input  logic [DATA_W-1:0]  rf_wdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ENTRY_W-1:0] out_data,
  output logic [LVL_W-1:0]   fifo_level,
  output logic               overflow,
  output logic [15:0]        drop_cnt,
  output logic               done,
  output logic [1:0]         state
);

  localparam int ARM_W  = (CYCLE_LIMIT > 1) ? $clog2(CYCLE_LIMIT) : 1;
  localparam int LIM_M1 = (CYCLE_LIMIT == 0) ? 0 : CYCLE_LIMIT - 1;

  trace_state_t      st;
  logic [TS_W-1:0]   ts;
  logic [ARM_W-1:0]  arm_cnt;
  logic [DATA_W-1:0] shadow [NUM_REGS];
  logic              evt, changed, pop, full, empty, drop;

  assign state = st;
  assign done  = (st == ST_DONE);

  // Free-running timestamp, wraps at 2^TS_W.
  always_ff @(posedge mips_clk or negedge mips_rst) begin
    if (!mips_rst) ts <= '0;
    else           ts <= ts + TS_W'(1);
  end

  // Capture window FSM; arm_cnt counts cycles spent in ARMED.
  always_ff @(posedge mips_clk or negedge mips_rst) begin
    if (!mips_rst) begin
      st      <= ST_IDLE;
      arm_cnt <= '0;
    end else begin
      case (st)
        ST_IDLE: if (trace_en) begin
          st      <= ST_ARMED;
          arm_cnt <= '0;
        end
        ST_ARMED: begin
          if (!trace_en)
            st <= ST_IDLE;
          else if (CYCLE_LIMIT != 0 && arm_cnt == ARM_W'(LIM_M1))
            st <= ST_DONE;
          else if (CYCLE_LIMIT != 0)
            arm_cnt <= arm_cnt + ARM_W'(1);
        end
        ST_DONE: if (clr_stat) st <= ST_IDLE;
        default: st <= ST_IDLE;
      endcase
    end
  end

  // Shadow copy of the regfile, updated on every real write whatever the mask.
  always_ff @(posedge mips_clk or negedge mips_rst) begin
    if (!mips_rst) begin
      for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
    end else if (rf_we && rf_waddr != '0) begin
      shadow[rf_waddr] <= rf_wdata;
    end
  end

  // Event filter; compares against the shadow value before this write lands.
  assign changed = (rf_wdata != shadow[rf_waddr]);
  assign evt     = (st == ST_ARMED) && rf_we && (rf_waddr != '0) &&
                   trace_mask[rf_waddr] && ((CHANGE_ONLY == 0) || changed);
  assign pop       = out_valid && out_ready;
  assign drop      = evt && full && !pop;
  assign out_valid = !empty;

  trace_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .mips_clk (mips_clk),
    .mips_rst (mips_rst),
    .push     (evt),
    .pop      (pop),
    .wdata    ({ts, rf_waddr, rf_wdata}),
    .rdata    (out_data),
    .full     (full),
    .empty    (empty),
    .level    (fifo_level)
  );

  // Loss accounting; a clear in the same cycle as a drop still records that drop.
  always_ff @(posedge mips_clk or negedge mips_rst) begin
    if (!mips_rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clr_stat) begin
      overflow <= drop;
      drop_cnt <= drop ? 16'd1 : 16'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_mips_reg_trace_unit.sv
// Bench for the register-write tracer: two configurations share stimulus and
// are checked every cycle against a queue-based reference model.
module tb_mips_reg_trace_unit;

  logic        mips_clk = 1'b0;
  logic        mips_rst = 1'b0;
  logic        trace_en = 1'b0, clr_stat = 1'b0, rf_we = 1'b0, out_ready = 1'b0;
  logic [31:0] trace_mask = '0;
  logic [4:0]  rf_waddr = '0;
  logic [31:0] rf_wdata = '0;

  logic        v0, v1, of0, of1, dn0, dn1;
  logic [52:0] od0, od1;
  logic [4:0]  lv0;
  logic [2:0]  lv1;
  logic [15:0] dc0, dc1;
  logic [1:0]  st0, st1;

  int n_pass = 0, n_tot = 0;

  always #5 mips_clk = ~mips_clk;

  mips_reg_trace_unit #(.DATA_W(32), .TS_W(16), .DEPTH(16), .CYCLE_LIMIT(1000), .CHANGE_ONLY(0)) u_dut0 (
    .mips_clk(mips_clk), .mips_rst(mips_rst), .trace_en(trace_en), .clr_stat(clr_stat),
    .trace_mask(trace_mask), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .out_valid(v0), .out_ready(out_ready), .out_data(od0), .fifo_level(lv0),
    .overflow(of0), .drop_cnt(dc0), .done(dn0), .state(st0));

  mips_reg_trace_unit #(.DATA_W(32), .TS_W(16), .DEPTH(4), .CYCLE_LIMIT(10), .CHANGE_ONLY(1)) u_dut1 (
    .mips_clk(mips_clk), .mips_rst(mips_rst), .trace_en(trace_en), .clr_stat(clr_stat),
    .trace_mask(trace_mask), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .out_valid(v1), .out_ready(out_ready), .out_data(od1), .fifo_level(lv1),
    .overflow(of1), .drop_cnt(dc1), .done(dn1), .state(st1));

  // Reference model: state 0 idle, 1 armed, 2 done; queue as a shifted array.
  int          m_st [2], m_arm [2], m_ov [2], m_dc [2], m_cnt [2];
  int          m_ts;
  logic [31:0] m_sh [2][32];
  logic [63:0] m_q  [2][16];

  function automatic int dep(input int c); return (c == 0) ? 16 : 4;   endfunction
  function automatic int lim(input int c); return (c == 0) ? 1000 : 10; endfunction
  function automatic int co (input int c); return (c == 0) ? 0 : 1;    endfunction

  task automatic mreset();
    m_ts = 0;
    for (int c = 0; c < 2; c++) begin
      m_st[c] = 0; m_arm[c] = 0; m_ov[c] = 0; m_dc[c] = 0; m_cnt[c] = 0;
      for (int r = 0; r < 32; r++) m_sh[c][r] = '0;
    end
  endtask

  task automatic mstep(input int c);
    bit pop, ev, drp;
    pop = (m_cnt[c] > 0) && out_ready;
    ev  = (m_st[c] == 1) && rf_we && (rf_waddr != 0) && trace_mask[rf_waddr] &&
          (co(c) == 0 || rf_wdata != m_sh[c][rf_waddr]);
    drp = ev && (m_cnt[c] == dep(c)) && !pop;
    if (clr_stat) begin m_ov[c] = 0; m_dc[c] = 0; end
    if (drp) begin m_ov[c] = 1; if (m_dc[c] < 65535) m_dc[c]++; end
    if (pop) begin
      for (int i = 0; i < m_cnt[c] - 1; i++) m_q[c][i] = m_q[c][i+1];
      m_cnt[c]--;
    end
    if (ev && !drp) begin
      m_q[c][m_cnt[c]] = {11'b0, 16'(m_ts), rf_waddr, rf_wdata};
      m_cnt[c]++;
    end
    if (rf_we && rf_waddr != 0) m_sh[c][rf_waddr] = rf_wdata;
    case (m_st[c])
      0: if (trace_en) begin m_st[c] = 1; m_arm[c] = 0; end
      1: if (!trace_en) m_st[c] = 0;
         else if (m_arm[c] == lim(c) - 1) m_st[c] = 2;
         else m_arm[c]++;
      default: if (clr_stat) m_st[c] = 0;
    endcase
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_cfg(input int c, input logic v, input logic [52:0] d, input logic [63:0] lv,
                         input logic of, input logic [15:0] dc, input logic dn, input logic [1:0] st);
    chk($sformatf("c%0d out_valid", c),  64'(v),  64'(m_cnt[c] > 0));
    chk($sformatf("c%0d out_data", c),   64'(d),  (m_cnt[c] > 0) ? m_q[c][0] : 64'd0);
    chk($sformatf("c%0d fifo_level", c), lv,      64'(m_cnt[c]));
    chk($sformatf("c%0d overflow", c),   64'(of), 64'(m_ov[c]));
    chk($sformatf("c%0d drop_cnt", c),   64'(dc), 64'(m_dc[c]));
    chk($sformatf("c%0d done", c),       64'(dn), 64'(m_st[c] == 2));
    chk($sformatf("c%0d state", c),      64'(st), 64'(m_st[c]));
  endtask

  task automatic check_all();
    chk_cfg(0, v0, od0, 64'(lv0), of0, dc0, dn0, st0);
    chk_cfg(1, v1, od1, 64'(lv1), of1, dc1, dn1, st1);
  endtask

  // One clock: model takes the edge, then outputs are compared 1 time unit later.
  task automatic tick();
    if (mips_rst) begin
      mstep(0);
      mstep(1);
      m_ts = (m_ts + 1) % 65536;
    end
    @(posedge mips_clk);
    #1;
    check_all();
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    rf_we = 1'b1; rf_waddr = a; rf_wdata = d;
    tick();
    rf_we = 1'b0;
  endtask

  task automatic rearm();
    trace_en = 1'b0; clr_stat = 1'b1; tick();
    trace_en = 1'b1; clr_stat = 1'b0; tick();
  endtask

  task automatic drain();
    rf_we = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [2:0] lv_snap;
    mreset();
    repeat (3) @(posedge mips_clk);
    #1;
    check_all();
    mips_rst = 1'b1;

    // Single traced write lands with its own timestamp, visible the cycle after.
    trace_mask = 32'h100; trace_en = 1'b1;
    tick();
    repeat (4) tick();
    chk("t1 valid before", 64'(v0), 64'd0);
    wr(5'd8, 32'h1234);
    chk("t1 valid after", 64'(v0), 64'd1);
    chk("t1 entry", 64'(od0), {11'b0, 16'd5, 5'd8, 32'h1234});

    // Unmasked register and r0 never log.
    wr(5'd9, 32'h55);
    wr(5'd0, 32'h66);
    trace_mask = 32'h101;
    wr(5'd0, 32'h77);
    chk("t2 level", 64'(lv0), 64'd1);
    trace_mask = 32'h100;
    drain();

    // Change-only mode suppresses the repeated value.
    rearm();
    wr(5'd8, 32'd7); wr(5'd8, 32'd7); wr(5'd8, 32'd8);
    chk("t3 co level", 64'(lv1), 64'd2);
    chk("t3 all level", 64'(lv0), 64'd3);
    chk("t3 co head", 64'(od1[31:0]), 64'd7);
    drain();

    // Full FIFO with simultaneous push and pop, then clear racing a drop.
    rearm();
    for (int i = 0; i < 4; i++) wr(5'd8, 32'h20 + i);
    chk("fp level", 64'(lv1), 64'd4);
    out_ready = 1'b1;
    wr(5'd8, 32'h24);
    out_ready = 1'b0;
    chk("fp level kept", 64'(lv1), 64'd4);
    chk("fp no drop", 64'(dc1), 64'd0);
    chk("fp head", 64'(od1[31:0]), 64'h21);
    clr_stat = 1'b1;
    wr(5'd8, 32'h25);
    clr_stat = 1'b0;
    chk("clr+drop cnt", 64'(dc1), 64'd1);
    chk("clr+drop ov", 64'(of1), 64'd1);
    drain();

    // Overflow accounting and in-order drain.
    rearm();
    for (int i = 0; i < 20; i++) wr(5'd8, 32'h100 + i);
    chk("t4 level", 64'(lv0), 64'd16);
    chk("t4 overflow", 64'(of0), 64'd1);
    chk("t4 drop_cnt", 64'(dc0), 64'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t4 drain order", 64'(od0[31:0]), 64'h100 + 64'(i));
      tick();
    end
    out_ready = 1'b0;
    chk("t4 empty", 64'(v0), 64'd0);
    drain();

    // Cycle-limited window.
    rearm();
    repeat (9) tick();
    chk("t5 not done", 64'(dn1), 64'd0);
    tick();
    chk("t5 done", 64'(dn1), 64'd1);
    lv_snap = lv1;
    wr(5'd8, 32'hDEAD);
    chk("t5 ignored", 64'(lv1), 64'(lv_snap));
    trace_en = 1'b0; clr_stat = 1'b1; tick(); clr_stat = 1'b0;
    chk("t5 idle", 64'(st1), 64'd0);
    drain();

    // Randomized traffic.
    rearm();
    for (int i = 0; i < 300; i++) begin
      trace_en   = ($urandom_range(0, 9) != 0);
      clr_stat   = ($urandom_range(0, 19) == 0);
      trace_mask = $urandom() | 32'h0000_0F00;
      rf_we      = ($urandom_range(0, 9) < 7);
      rf_waddr   = ($urandom_range(0, 1) != 0) ? 5'(8 + $urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      rf_wdata   = 32'($urandom_range(0, 3));
      out_ready  = ($urandom_range(0, 1) != 0);
      tick();
    end
    clr_stat = 1'b0;
    drain();

    // Asynchronous reset mid-drain discards the FIFO at once.
    trace_mask = 32'h100;
    rearm();
    for (int i = 0; i < 5; i++) wr(5'd8, 32'h300 + i);
    chk("t6 level", 64'(lv0), 64'd5);
    #3;
    mips_rst = 1'b0;
    mreset();
    #1;
    chk("t6 valid0", 64'(v0), 64'd0);
    chk("t6 level0", 64'(lv0), 64'd0);
    chk("t6 valid1", 64'(v1), 64'd0);
    @(posedge mips_clk); #1;
    tick();
    mips_rst = 1'b1;
    trace_en = 1'b1;
    tick();
    wr(5'd8, 32'hABCD);
    chk("t6 ts restart", 64'(od0[52:37]), 64'd1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
